// File: rtl/arbiter_puf_eval.sv
// Arbiter PUF evaluator: races CHANNELS swap-mux chains NEVAL times per challenge and majority-votes each channel.
// Latency: response valid exactly NEVAL*(2*SETTLE+1) clk cycles after the accepting edge.
// Backpressure: one challenge in flight; response held stable in DONE until rsp_ready, then chal_ready returns the next cycle.
module arbiter_puf_eval #(
    parameter int STAGES   = 8,
    parameter int CHANNELS = 8,
    parameter int NEVAL    = 7,
    parameter int SETTLE   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                chal_valid,
    output logic                chal_ready,
    input  logic [STAGES-1:0]   chal,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [CHANNELS-1:0] rsp,
    output logic [CHANNELS-1:0] rsp_unstable,
    output logic                busy,
    input  logic                tst_en,
    input  logic [CHANNELS-1:0] tst_bits
);

    localparam int CW = $clog2(NEVAL + 1);
    localparam int SW = $clog2(SETTLE);
    localparam logic [CW-1:0] NEV   = CW'(NEVAL);
    localparam logic [CW-1:0] HALF  = CW'(NEVAL / 2);
    localparam logic [SW-1:0] SLAST = SW'(SETTLE - 1);

    if (NEVAL < 1 || NEVAL > 15 || (NEVAL % 2) == 0) begin : g_bad_neval
        $error("arbiter_puf_eval: NEVAL must be odd and within 1..15");
    end
    if (SETTLE < 3) begin : g_bad_settle
        $error("arbiter_puf_eval: SETTLE must be at least 3");
    end

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_FIRE, S_CAPTURE, S_DONE} state_t;

    state_t              state;
    logic [SW-1:0]       phase_cnt;
    logic [CW-1:0]       eval_cnt;
    logic [CW-1:0]       ones    [CHANNELS];
    logic [CW-1:0]       ones_nx [CHANNELS];
    logic [STAGES-1:0]   chal_r;
    logic                launch;
    logic [CHANNELS-1:0] samp;
    logic [CHANNELS-1:0] cap_bits;

    assign chal_ready = rst_n && ena && (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign cap_bits   = tst_en ? tst_bits : samp;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic pa, pb, tmp;
        logic arb_q, sync1, sync2;

        // Race chain: both paths start from launch; a set challenge bit swaps the paths at that stage
        always_comb begin
            pa  = launch;
            pb  = launch;
            tmp = 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                if (chal_r[i]) begin
                    tmp = pa;
                    pa  = pb;
                    pb  = tmp;
                end
            end
        end

        // Arbiter: path A's edge samples path B; no reset, only post-launch samples are ever consumed
        always_ff @(posedge pa) begin
            arb_q <= pb;
        end

        // Two-flop synchroniser bringing the arbiter decision into clk
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= arb_q;
                sync2 <= sync1;
            end
        end

        assign samp[c] = sync2;
    end

    // Vote counters including this cycle's sample, so DONE can be decided on the final capture edge
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            ones_nx[c] = ones[c] + CW'(cap_bits[c]);
        end
    end

    // Evaluation controller: ARM/FIRE/CAPTURE repeated NEVAL times, then hold the response in DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            phase_cnt    <= '0;
            eval_cnt     <= '0;
            chal_r       <= '0;
            launch       <= 1'b0;
            rsp          <= '0;
            rsp_unstable <= '0;
            rsp_valid    <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) ones[c] <= '0;
        end else if (!ena && (state == S_ARM || state == S_FIRE || state == S_CAPTURE)) begin
            // Abort discards the partial vote and parks the chains low
            state     <= S_IDLE;
            phase_cnt <= '0;
            eval_cnt  <= '0;
            launch    <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) ones[c] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (chal_valid && ena) begin
                        chal_r    <= chal;
                        eval_cnt  <= '0;
                        phase_cnt <= '0;
                        state     <= S_ARM;
                        for (int c = 0; c < CHANNELS; c++) ones[c] <= '0;
                    end
                end
                S_ARM: begin
                    if (phase_cnt == SLAST) begin
                        phase_cnt <= '0;
                        launch    <= 1'b1;
                        state     <= S_FIRE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_FIRE: begin
                    if (phase_cnt == SLAST) begin
                        phase_cnt <= '0;
                        launch    <= 1'b0;
                        state     <= S_CAPTURE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    for (int c = 0; c < CHANNELS; c++) ones[c] <= ones_nx[c];
                    eval_cnt <= eval_cnt + 1'b1;
                    if (eval_cnt == NEV - 1'b1) begin
                        state     <= S_DONE;
                        rsp_valid <= 1'b1;
                        for (int c = 0; c < CHANNELS; c++) begin
                            rsp[c]          <= (ones_nx[c] > HALF);
                            rsp_unstable[c] <= (ones_nx[c] != '0) && (ones_nx[c] != NEV);
                        end
                    end else begin
                        state <= S_ARM;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter_puf_eval.sv
// Testbench for arbiter_puf_eval with NEVAL=3, SETTLE=3, CHANNELS=8.
// Expected responses are queued when a challenge is accepted; a negedge monitor pops them when rsp_valid rises.
// Inputs change 2ns after posedge; outputs are sampled on negedge.
module tb_arbiter_puf_eval;

    localparam int LAT = 21;

    typedef struct {
        logic [7:0] rsp;
        logic [7:0] uns;
        int         acc;
        bit         chk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, ena, chal_valid, chal_ready, rsp_valid, rsp_ready, busy, tst_en;
    logic [7:0] chal, rsp, rsp_unstable, tst_bits;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   prev_vld = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    arbiter_puf_eval #(.STAGES(8), .CHANNELS(8), .NEVAL(3), .SETTLE(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .chal_valid   (chal_valid),
        .chal_ready   (chal_ready),
        .chal         (chal),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp          (rsp),
        .rsp_unstable (rsp_unstable),
        .busy         (busy),
        .tst_en       (tst_en),
        .tst_bits     (tst_bits)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // mode 0: no response expected, 1: latency only, 2: latency and data
    task automatic send(input logic [7:0] c, input logic [7:0] er, input logic [7:0] eu, input int mode);
        bit   got = 1'b0;
        exp_t e;
        chal       = c;
        chal_valid = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (chal_ready) begin
                got = 1'b1;
                if (mode != 0) begin
                    e.rsp = er;
                    e.uns = eu;
                    e.acc = cyc + 1;
                    e.chk = (mode == 2);
                    sb.push_back(e);
                end
            end
        end
        check("accept_seen", 32'(got), 32'd1);
        @(posedge clk);
        #2;
        chal_valid = 1'b0;
        chal       = ~c;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) ok = 1'b1;
        end
        check("drained", 32'(ok), 32'd1);
    endtask

    // Scoreboard monitor: every rising rsp_valid must match the oldest queued expectation
    always @(negedge clk) begin
        if (rsp_valid && !prev_vld) begin
            check("rsp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("latency", 32'(cyc - mon_e.acc), 32'(LAT));
                if (mon_e.chk) begin
                    check("rsp", 32'(rsp), 32'(mon_e.rsp));
                    check("rsp_unstable", 32'(rsp_unstable), 32'(mon_e.uns));
                end
            end
        end
        prev_vld = rsp_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timed out at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int  rises;
        int  run;
        bit  pl;

        rst_n = 1'b0; ena = 1'b1; chal_valid = 1'b0; chal = 8'h00;
        rsp_ready = 1'b1; tst_en = 1'b1; tst_bits = 8'h00;

        // Reset state
        step(3);
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp", 32'(rsp), 32'd0);
        check("rst_unstable", 32'(rsp_unstable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_chal_ready", 32'(chal_ready), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_chal_ready", 32'(chal_ready), 32'd1);

        // Stable vote
        step(1);
        tst_bits = 8'hA5;
        send(8'h3C, 8'hA5, 8'h00, 2);
        wait_done();

        // Split vote: captures at accept+7, +14, +21
        step(1);
        tst_bits = 8'hFF;
        send(8'h81, 8'h0F, 8'hFF, 2);
        step(7);
        tst_bits = 8'h00;
        step(7);
        tst_bits = 8'h0F;
        wait_done();

        // Backpressure
        step(1);
        rsp_ready = 1'b0;
        tst_bits  = 8'h5A;
        send(8'h12, 8'h5A, 8'h00, 2);
        for (int k = 0; k < 60 && !rsp_valid; k++) @(negedge clk);
        check("bp_valid_seen", 32'(rsp_valid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_rsp", 32'(rsp), 32'h5A);
            check("bp_hold_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #2;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_not_yet", 32'(chal_ready), 32'd0);
        @(posedge clk); #2;
        @(negedge clk);
        check("bp_busy_after", 32'(busy), 32'd0);
        check("bp_chal_ready_after", 32'(chal_ready), 32'd1);
        check("bp_valid_after", 32'(rsp_valid), 32'd0);

        // Abort during the second FIRE phase
        step(1);
        tst_bits = 8'h33;
        send(8'h47, 8'h00, 8'h00, 0);
        step(10);
        @(negedge clk);
        check("abort_in_fire_launch", 32'(dut.launch), 32'd1);
        @(posedge clk); #2;
        ena = 1'b0;
        step(1);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_launch", 32'(dut.launch), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        step(30);
        @(negedge clk);
        check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk); #2;
        ena      = 1'b1;
        tst_bits = 8'hA5;
        send(8'h47, 8'hA5, 8'h00, 2);
        wait_done();

        // Reset while in CAPTURE, chal_valid held for a fresh accept afterwards
        step(1);
        tst_bits = 8'hFF;
        send(8'h55, 8'h00, 8'h00, 0);
        step(6);
        rst_n      = 1'b0;
        chal_valid = 1'b1;
        chal       = 8'h66;
        tst_bits   = 8'hA5;
        @(negedge clk);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        check("rstmid_chal_ready_low", 32'(chal_ready), 32'd0);
        @(posedge clk); #2;
        @(negedge clk);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstmid_rsp", 32'(rsp), 32'd0);
        check("rstmid_unstable", 32'(rsp_unstable), 32'd0);
        check("rstmid_launch", 32'(dut.launch), 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check("rstmid_reaccept_ready", 32'(chal_ready), 32'd1);
        mon_e.rsp = 8'hA5; mon_e.uns = 8'h00; mon_e.acc = cyc + 1; mon_e.chk = 1'b1;
        sb.push_back(mon_e);
        @(posedge clk); #2;
        chal_valid = 1'b0;
        wait_done();

        // Chain smoke with real arbiter samples: count launch pulses
        step(1);
        tst_en = 1'b0;
        send(8'hC3, 8'h00, 8'h00, 1);
        rises = 0; run = 0; pl = 1'b0;
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            if (dut.launch) run++;
            else if (pl) begin
                check("launch_width", 32'(run), 32'd3);
                run = 0;
            end
            if (dut.launch && !pl) rises++;
            pl = dut.launch;
        end
        check("launch_pulses", 32'(rises), 32'd3);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
